// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter for a single external memory bus.
// Optional bus wait timeout is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_i_req,
  input  logic [AW-1:0]   i_i_addr,
  output logic            o_i_ack,
  output logic [DW-1:0]   o_i_rdata,
  output logic            o_i_err,
  output logic            o_i_stall,
  input  logic            i_d_req,
  input  logic            i_d_we,
  input  logic [AW-1:0]   i_d_addr,
  input  logic [DW-1:0]   i_d_wdata,
  input  logic [DW/8-1:0] i_d_be,
  output logic            o_d_ack,
  output logic [DW-1:0]   o_d_rdata,
  output logic            o_d_err,
  output logic            o_d_stall,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [AW-1:0]   o_bus_addr,
  output logic [DW-1:0]   o_bus_wdata,
  output logic [DW/8-1:0] o_bus_be,
  input  logic            i_bus_ack,
  input  logic [DW-1:0]   i_bus_rdata
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be in 1..65535");
  end

  state_t state;
  logic   last_gnt;   // 1 = D-port held the bus last
  logic   timeout;
  logic   grant_d;
  logic   done;

`ifdef BUS_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Fires on the TIMEOUT-th busy cycle without an ack; a real ack wins.
  assign timeout = (state != IDLE) && !i_bus_ack && (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == IDLE)
      wait_cnt <= '0;
    else if (!i_bus_ack)
      wait_cnt <= wait_cnt + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Round-robin only matters on a conflict: D wins unless it went last.
  assign grant_d = i_d_req && (!i_i_req || !last_gnt);
  assign done    = (state != IDLE) && (i_bus_ack || timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_i_req || i_d_req) begin
            o_bus_req <= 1'b1;
            last_gnt  <= grant_d;
            if (grant_d) begin
              state       <= DBUSY;
              o_bus_we    <= i_d_we;
              o_bus_addr  <= i_d_addr;
              o_bus_wdata <= i_d_wdata;
              o_bus_be    <= i_d_be;
            end else begin
              state       <= IBUSY;
              o_bus_we    <= 1'b0;
              o_bus_addr  <= i_i_addr;
              o_bus_wdata <= '0;
              o_bus_be    <= '1;
            end
          end
        end
        IBUSY, DBUSY: begin
          if (done) begin
            state     <= IDLE;
            o_bus_req <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          o_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_i_ack   = done && (state == IBUSY);
  assign o_d_ack   = done && (state == DBUSY);
  assign o_i_err   = timeout && (state == IBUSY);
  assign o_d_err   = timeout && (state == DBUSY);
  assign o_i_rdata = timeout ? '0 : i_bus_rdata;
  assign o_d_rdata = timeout ? '0 : i_bus_rdata;
  assign o_i_stall = i_i_req && !o_i_ack;
  assign o_d_stall = i_d_req && !o_d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected bus transactions are queued
// as requests are driven and checked when the DUT puts them on the bus.
module tb_mem_bus_arbiter;
  localparam int AW = 32, DW = 32, BW = DW/8, TO = 4;

  logic clk = 1'b0, rst;
  logic i_i_req, i_d_req, i_d_we, i_bus_ack;
  logic [AW-1:0] i_i_addr, i_d_addr;
  logic [DW-1:0] i_d_wdata, i_bus_rdata;
  logic [BW-1:0] i_d_be;
  logic o_i_ack, o_i_err, o_i_stall, o_d_ack, o_d_err, o_d_stall;
  logic o_bus_req, o_bus_we;
  logic [DW-1:0] o_i_rdata, o_d_rdata, o_bus_wdata;
  logic [AW-1:0] o_bus_addr;
  logic [BW-1:0] o_bus_be;

  typedef struct {
    logic          d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } txn_t;

  txn_t          exp_q[$];
  logic [AW-1:0] last_addr;
  int            n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_i_req(i_i_req), .i_i_addr(i_i_addr), .o_i_ack(o_i_ack), .o_i_rdata(o_i_rdata),
    .o_i_err(o_i_err), .o_i_stall(o_i_stall),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .i_d_be(i_d_be), .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
    .o_d_stall(o_d_stall),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    i_i_req = 0; i_d_req = 0; i_d_we = 0; i_bus_ack = 0;
    i_i_addr = '0; i_d_addr = '0; i_d_wdata = '0; i_d_be = '0; i_bus_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_q.delete();
  endtask

  // Bounded wait for the bus request; returns at the negedge it is seen.
  task automatic wait_bus(output bit ok);
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_bus_req === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h be=%h want all 0",
                         o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be);
    end
    n_tests++;
    if ({o_i_ack, o_d_ack, o_i_err, o_d_err, o_i_stall, o_d_stall} !== 6'b0) begin
      n_fail++; $display("FAIL reset_comb: got %b want 000000",
                         {o_i_ack, o_d_ack, o_i_err, o_d_err, o_i_stall, o_d_stall});
    end
  endtask

  task automatic test_single_fetch();
    txn_t e;
    next_cycle();
    i_i_req = 1; i_i_addr = 32'h100;
    exp_q.push_back('{d: 0, we: 0, addr: 32'h100, wdata: '0, be: '1});
    @(negedge clk);   // cycle 0
    n_tests++;
    if ({o_bus_req, o_i_stall} !== 2'b01) begin
      n_fail++; $display("FAIL fetch_c0: got req,stall=%b want 01", {o_bus_req, o_i_stall});
    end
    next_cycle(); @(negedge clk);   // cycle 1
    e = exp_q.pop_front();
    n_tests++;
    if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== {1'b1, e.we, e.addr, e.wdata, e.be}) begin
      n_fail++; $display("FAIL fetch_bus: got req=%b we=%b addr=%h wdata=%h be=%h want 1 %b %h %h %h",
                         o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be, e.we, e.addr, e.wdata, e.be);
    end
    next_cycle(); @(negedge clk);   // cycle 2
    n_tests++;
    if ({o_bus_req, o_i_stall, o_i_ack, o_bus_addr} !== {3'b110, 32'h100}) begin
      n_fail++; $display("FAIL fetch_c2: got req,stall,ack=%b addr=%h want 110 100",
                         {o_bus_req, o_i_stall, o_i_ack}, o_bus_addr);
    end
    next_cycle(); i_bus_ack = 1; i_bus_rdata = 32'hDEADBEEF;
    @(negedge clk);   // cycle 3
    n_tests++;
    if ({o_bus_req, o_i_ack, o_i_stall, o_d_ack} !== 4'b1100) begin
      n_fail++; $display("FAIL fetch_ack: got req,iack,stall,dack=%b want 1100",
                         {o_bus_req, o_i_ack, o_i_stall, o_d_ack});
    end
    n_tests++;
    if (o_i_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch_rdata: got %h want deadbeef", o_i_rdata);
    end
    next_cycle(); i_bus_ack = 0; i_i_req = 0;
    @(negedge clk);
    n_tests++;
    if (o_bus_req !== 1'b0) begin
      n_fail++; $display("FAIL fetch_release: got req=%b want 0", o_bus_req);
    end
    last_addr = 32'h100;
  endtask

  task automatic test_round_robin();
    txn_t e;
    bit   ok;
    bit   model_last;
    bit   exp_d;
    do_reset();
    model_last = 0;
    next_cycle();
    i_i_req = 1; i_i_addr = 32'h200;
    i_d_req = 1; i_d_we = 0; i_d_addr = 32'h300; i_d_be = '1; i_d_wdata = 32'h55;
    for (int k = 0; k < 6; k++) begin
      exp_d = ~model_last;
      model_last = exp_d;
      if (exp_d) exp_q.push_back('{d: 1, we: i_d_we, addr: i_d_addr, wdata: i_d_wdata, be: i_d_be});
      else       exp_q.push_back('{d: 0, we: 0, addr: i_i_addr, wdata: '0, be: '1});
      wait_bus(ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL rr_timeout[%0d]: got no bus request want one", k);
      end
      e = exp_q.pop_front();
      n_tests++;
      if ({o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== {e.we, e.addr, e.wdata, e.be}) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got addr=%h want %h (%s)", k, o_bus_addr, e.addr,
                           e.d ? "D" : "I");
      end
      i_bus_ack = 1; #1;
      n_tests++;
      if ({o_i_ack, o_d_ack, o_i_stall, o_d_stall} !== (e.d ? 4'b0110 : 4'b1001)) begin
        n_fail++; $display("FAIL rr_ack[%0d]: got iack,dack,istall,dstall=%b want %b", k,
                           {o_i_ack, o_d_ack, o_i_stall, o_d_stall}, e.d ? 4'b0110 : 4'b1001);
      end
      @(posedge clk); #1;
      i_bus_ack = 0;
      if (e.d) i_d_addr += 4; else i_i_addr += 4;
      last_addr = e.addr;
    end
    idle_inputs();
  endtask

  task automatic test_store_hold();
    txn_t e;
    bit   ok;
    next_cycle();
    i_d_req = 1; i_d_we = 1; i_d_addr = 32'h20; i_d_wdata = 32'h12345678; i_d_be = 4'b0011;
    exp_q.push_back('{d: 1, we: 1, addr: 32'h20, wdata: 32'h12345678, be: 4'b0011});
    wait_bus(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL store_timeout: got no bus request want one");
    end
    e = exp_q.pop_front();
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== {1'b1, e.we, e.addr, e.wdata, e.be}) begin
        n_fail++; $display("FAIL store_hold[%0d]: got req=%b we=%b addr=%h wdata=%h be=%b want 1 1 20 12345678 0011",
                           c, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be);
      end
      if (c == 0) begin
        i_d_addr = 32'h40; i_d_wdata = 32'hFFFF0000; i_d_be = 4'hF; i_d_we = 0;
      end else if (c == 1) begin
        i_d_req = 0;
      end
      if (c < 2) begin next_cycle(); @(negedge clk); end
    end
    i_bus_ack = 1; #1;
    n_tests++;
    if ({o_d_ack, o_d_stall, o_i_ack} !== 3'b100) begin
      n_fail++; $display("FAIL store_dropped_ack: got dack,dstall,iack=%b want 100",
                         {o_d_ack, o_d_stall, o_i_ack});
    end
    @(posedge clk); #1;
    idle_inputs();
    last_addr = 32'h20;
  endtask

  task automatic test_reset_abort();
    txn_t e;
    bit   ok;
    next_cycle();
    i_d_req = 1; i_d_we = 0; i_d_addr = 32'h80; i_d_be = '1;
    wait_bus(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL abort_timeout: got no bus request want one");
    end
    rst = 1; i_bus_ack = 1; #1;
    n_tests++;
    if ({o_bus_req, o_d_ack, o_i_ack} !== 3'b000) begin
      n_fail++; $display("FAIL abort_async: got req,dack,iack=%b want 000", {o_bus_req, o_d_ack, o_i_ack});
    end
    next_cycle();
    i_bus_ack = 0;
    i_i_req = 1; i_i_addr = 32'h500; i_d_addr = 32'h600;
    next_cycle();
    rst = 0;
    exp_q.push_back('{d: 1, we: 0, addr: 32'h600, wdata: '0, be: '1});
    wait_bus(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL abort_regrant_timeout: got no bus request want one");
    end
    e = exp_q.pop_front();
    n_tests++;
    if (o_bus_addr !== e.addr) begin
      n_fail++; $display("FAIL abort_regrant: got addr=%h want %h (D first)", o_bus_addr, e.addr);
    end
    i_bus_ack = 1;
    @(posedge clk); #1;
    idle_inputs();
    last_addr = e.addr;
  endtask

  task automatic test_idle_ack();
    txn_t e;
    @(negedge clk);
    i_bus_ack = 1; i_bus_rdata = 32'h1234; #1;
    n_tests++;
    if ({o_i_ack, o_d_ack, o_bus_req} !== 3'b000) begin
      n_fail++; $display("FAIL idle_ack_out: got iack,dack,req=%b want 000", {o_i_ack, o_d_ack, o_bus_req});
    end
    @(posedge clk); #1;
    i_bus_ack = 0;
    @(negedge clk);
    n_tests++;
    if ({o_bus_req, o_bus_addr} !== {1'b0, last_addr}) begin
      n_fail++; $display("FAIL idle_ack_hold: got req=%b addr=%h want 0 %h", o_bus_req, o_bus_addr, last_addr);
    end
    next_cycle();
    i_i_req = 1; i_i_addr = 32'h700;
    exp_q.push_back('{d: 0, we: 0, addr: 32'h700, wdata: '0, be: '1});
    next_cycle(); @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if ({o_bus_req, o_bus_addr, o_bus_be} !== {1'b1, e.addr, e.be}) begin
      n_fail++; $display("FAIL idle_ack_grant: got req=%b addr=%h be=%h want 1 %h %h",
                         o_bus_req, o_bus_addr, o_bus_be, e.addr, e.be);
    end
    i_bus_ack = 1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_timeout();
    txn_t e;
    bit   bad;
    next_cycle();
    i_i_req = 1; i_i_addr = 32'h900; i_bus_rdata = 32'hCAFEF00D;
    exp_q.push_back('{d: 0, we: 0, addr: 32'h900, wdata: '0, be: '1});
    next_cycle(); @(negedge clk);   // first busy cycle
    e = exp_q.pop_front();
    n_tests++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, e.addr}) begin
      n_fail++; $display("FAIL to_grant: got req=%b addr=%h want 1 %h", o_bus_req, o_bus_addr, e.addr);
    end
`ifdef BUS_TIMEOUT_EN
    bad = 0;
    for (int c = 1; c < TO; c++) begin
      if ({o_bus_req, o_i_ack, o_i_err} !== 3'b100) bad = 1;
      next_cycle(); @(negedge clk);
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL to_early: got early ack/err or dropped req want req held");
    end
    n_tests++;
    if ({o_i_ack, o_i_err, o_d_err, o_i_stall, o_i_rdata} !== {4'b1100, 32'h0}) begin
      n_fail++; $display("FAIL to_fire: got ack,err,derr,stall=%b rdata=%h want 1100 0",
                         {o_i_ack, o_i_err, o_d_err, o_i_stall}, o_i_rdata);
    end
    next_cycle(); i_i_req = 0;
    @(negedge clk);
    n_tests++;
    if ({o_bus_req, o_i_ack, o_i_err} !== 3'b000) begin
      n_fail++; $display("FAIL to_idle: got req,ack,err=%b want 000", {o_bus_req, o_i_ack, o_i_err});
    end
`else
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if ({o_bus_req, o_i_ack, o_i_err} !== 3'b100) bad = 1;
      next_cycle(); @(negedge clk);
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL to_wait_forever: got req dropped or ack/err want req held");
    end
    i_bus_ack = 1; #1;
    n_tests++;
    if ({o_i_ack, o_i_err, o_i_rdata} !== {2'b10, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL to_late_ack: got ack,err=%b rdata=%h want 10 cafef00d",
                         {o_i_ack, o_i_err}, o_i_rdata);
    end
    @(posedge clk); #1;
`endif
    idle_inputs();
  endtask

  initial begin
    rst = 1; idle_inputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_store_hold();
    test_reset_abort();
    test_idle_ack();
    test_timeout();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
